addsub_sequencer: RTL

Command-driven accumulator controller that sits directly upstream of the 8-bit adder/subtractor. It accepts LOAD/ADD/SUB/CLEAR commands over a valid/ready handshake and drives the adder/subtractor's operand and mode inputs from an internal accumulator and a latched operand. It captures the result and overflow back into the accumulator and returns each outcome over a second valid/ready handshake. It also keeps a sticky overflow flag for software.

---
 rtl/addsub_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/addsub_sequencer.sv
// Command-driven accumulator controller feeding an external 8-bit adder/subtractor.
// Executes LOAD/ADD/SUB/CLEAR with valid/ready command and response handshakes.
module addsub_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_mode,
  input  logic [WIDTH-1:0] as_result,
  input  logic             as_ovfl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic             rsp_ovfl,
  output logic             sticky_ovfl,
  input  logic             sticky_clr
);

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpAdd   = 2'b01;
  localparam logic [1:0] OpSub   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             rsp_ovfl_q, rsp_ovfl_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    acc_d      = acc_q;
    rsp_ovfl_d = rsp_ovfl_q;
    sticky_d   = sticky_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;

    // Software clear is applied first so a same-cycle overflow set takes priority.
    if (sticky_clr) sticky_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (op_q)
          OpLoad: begin
            acc_d      = data_q;
            rsp_ovfl_d = 1'b0;
          end
          OpAdd, OpSub: begin
            acc_d      = as_result;
            rsp_ovfl_d = as_ovfl;
            if (as_ovfl) sticky_d = 1'b1;
          end
          OpClear: begin
            acc_d      = '0;
            rsp_ovfl_d = 1'b0;
            sticky_d   = 1'b0;
          end
          default: ;
        endcase
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpLoad;
      data_q     <= '0;
      acc_q      <= '0;
      rsp_ovfl_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
      rsp_ovfl_q <= rsp_ovfl_d;
      sticky_q   <= sticky_d;
    end
  end

  // acc only changes at the end of EXEC, so it doubles as the held response value.
  assign as_a        = acc_q;
  assign as_b        = data_q;
  assign as_mode     = (op_q == OpSub);
  assign rsp_acc     = acc_q;
  assign rsp_ovfl    = rsp_ovfl_q;
  assign sticky_ovfl = sticky_q;

endmodule
